// File: rtl/sl_bank_seq.sv
// Source-line bank with command sequencer: holds N_DAC*N_GROUPS line voltages, drives them in write mode, streams sampled array groups to the ADC in read mode.
// Latency: load done SETTLE_CYC+1 cycles after accept; first adc_valid SETTLE_CYC+1 cycles after a read accept (next cycle when SETTLE_CYC=0).
// Backpressure: adc_ready low holds adc_bus/adc_group stable indefinitely; cmd_ready is high only in IDLE and commands seen while busy are dropped.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_op selects LOAD_ALL/LOAD_ADDR/READ_GRP/READ_ALL
//   cmd_addr                line address (LOAD_ADDR) or any line inside the wanted group (READ_GRP)
//   dac_bus                 DAC channel voltages, sampled on the accept edge
//   arr_in / arr_out        array return voltages / voltages driven onto the array
//   adc_bus/adc_valid/adc_ready/adc_group  sampled group stream to the ADC
//   busy, done, err         status: not idle, command completed pulse, illegal command pulse
module sl_bank_seq #(
  parameter int N_DAC      = 8,
  parameter int N_GROUPS   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int ADDR_W     = ((N_DAC * N_GROUPS) > 1) ? $clog2(N_DAC * N_GROUPS) : 1,
  parameter int GRP_W      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  real               dac_bus [N_DAC],
  input  real               arr_in  [N_DAC*N_GROUPS],
  output real               arr_out [N_DAC*N_GROUPS],
  output real               adc_bus [N_DAC],
  output logic              adc_valid,
  input  logic              adc_ready,
  output logic [GRP_W-1:0]  adc_group,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N_SL  = N_DAC * N_GROUPS;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] OP_LOAD_ALL  = 2'd0;
  localparam logic [1:0] OP_LOAD_ADDR = 2'd1;
  localparam logic [1:0] OP_READ_GRP  = 2'd2;
  localparam logic [1:0] OP_READ_ALL  = 2'd3;

  // One extra bit so the bound compare also works when N_SL is a power of 2.
  localparam logic [ADDR_W:0]  SL_LIM = (ADDR_W+1)'(N_SL);
  localparam logic [GRP_W-1:0] LAST_G = GRP_W'(N_GROUPS - 1);
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    XFER   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] settle_cnt, cnt_d;
  logic [GRP_W-1:0] grp, grp_d;
  logic             read_phase, rp_d;
  logic             rd_all, all_d;
  logic             err_r, err_d;

  logic             accept;
  logic             addr_oob;
  logic             illegal;
  logic [GRP_W-1:0] addr_grp;
  logic             load_all, load_addr;
  logic             latch_en;
  logic [GRP_W-1:0] latch_g;

  real              line [N_SL];

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign addr_oob  = ({1'b0, cmd_addr} >= SL_LIM);
  assign illegal   = addr_oob && ((cmd_op == OP_LOAD_ADDR) || (cmd_op == OP_READ_GRP));
  assign addr_grp  = GRP_W'(32'(cmd_addr) / N_DAC);

  assign adc_valid = (state == XFER);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_r;
  assign adc_group = grp;

  // Next-state and datapath control.
  always_comb begin
    state_d   = state;
    cnt_d     = settle_cnt;
    grp_d     = grp;
    rp_d      = read_phase;
    all_d     = rd_all;
    err_d     = 1'b0;
    load_all  = 1'b0;
    load_addr = 1'b0;
    latch_en  = 1'b0;
    latch_g   = grp;

    case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            // Swallowed: flagged on the next cycle, no state change.
            err_d = 1'b1;
          end else begin
            case (cmd_op)
              OP_LOAD_ALL:  load_all  = 1'b1;
              OP_LOAD_ADDR: load_addr = 1'b1;
              default: begin
                rp_d  = 1'b1;
                all_d = (cmd_op == OP_READ_ALL);
                grp_d = (cmd_op == OP_READ_ALL) ? '0 : addr_grp;
              end
            endcase
            if (SETTLE_CYC == 0) begin
              if (rp_d) begin
                state_d  = XFER;
                latch_en = 1'b1;
                latch_g  = grp_d;
              end else begin
                state_d = DONE;
              end
            end else begin
              state_d = SETTLE;
              cnt_d   = CNT_LD;
            end
          end
        end
      end

      SETTLE: begin
        if (settle_cnt == '0) begin
          if (read_phase) begin
            state_d  = XFER;
            latch_en = 1'b1;
            latch_g  = grp;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = settle_cnt - 1'b1;
        end
      end

      XFER: begin
        if (adc_ready) begin
          if (!rd_all || (grp == LAST_G)) begin
            state_d = DONE;
          end else begin
            // Back-to-back groups: sample the next group on the handshake edge.
            grp_d    = grp + 1'b1;
            latch_en = 1'b1;
            latch_g  = grp + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        rp_d    = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      grp        <= '0;
      read_phase <= 1'b0;
      rd_all     <= 1'b0;
      err_r      <= 1'b0;
      for (int i = 0; i < N_SL; i++) line[i] <= 0.0;
      for (int j = 0; j < N_DAC; j++) adc_bus[j] <= 0.0;
    end else begin
      state      <= state_d;
      settle_cnt <= cnt_d;
      grp        <= grp_d;
      read_phase <= rp_d;
      rd_all     <= all_d;
      err_r      <= err_d;

      // Line i is fed by DAC channel i % N_DAC in both load modes.
      for (int i = 0; i < N_SL; i++) begin
        if (load_all || (load_addr && (ADDR_W'(i) == cmd_addr))) begin
          line[i] <= dac_bus[i % N_DAC];
        end
      end

      if (latch_en) begin
        for (int j = 0; j < N_DAC; j++) begin
          for (int g = 0; g < N_GROUPS; g++) begin
            if (GRP_W'(g) == latch_g) adc_bus[j] <= arr_in[g*N_DAC + j];
          end
        end
      end
    end
  end

  // Lines are released (driven to 0.0) for the whole read, including its DONE cycle.
  always_comb begin
    for (int i = 0; i < N_SL; i++) begin
      arr_out[i] = read_phase ? 0.0 : line[i];
    end
  end

endmodule

// File: tb/tb_sl_bank_seq.sv
module tb_sl_bank_seq;

  localparam int ND   = 8;
  localparam int NG   = 4;
  localparam int NSL  = 32;
  localparam int SC   = 2;
  localparam int ND6  = 6;
  localparam int NG6  = 3;
  localparam int NSL6 = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (8 x 4)
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [4:0] cmd_addr = 5'd0;
  real        dac_bus [ND];
  real        arr_in  [NSL];
  real        arr_out [NSL];
  real        adc_bus [ND];
  logic       adc_valid;
  logic       adc_ready = 1'b0;
  logic [1:0] adc_group;
  logic       busy, done, err;

  // Non-power-of-2 instance (6 x 3)
  logic       cmd_valid6 = 1'b0;
  logic       cmd_ready6;
  logic [1:0] cmd_op6 = 2'd0;
  logic [4:0] cmd_addr6 = 5'd0;
  real        dac6     [ND6];
  real        arr_in6  [NSL6];
  real        arr_out6 [NSL6];
  real        adc_bus6 [ND6];
  logic       adc_valid6;
  logic       adc_ready6 = 1'b1;
  logic [1:0] adc_group6;
  logic       busy6, done6, err6;

  sl_bank_seq #(.N_DAC(ND), .N_GROUPS(NG), .SETTLE_CYC(SC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .dac_bus(dac_bus), .arr_in(arr_in), .arr_out(arr_out),
    .adc_bus(adc_bus), .adc_valid(adc_valid), .adc_ready(adc_ready), .adc_group(adc_group),
    .busy(busy), .done(done), .err(err)
  );

  sl_bank_seq #(.N_DAC(ND6), .N_GROUPS(NG6), .SETTLE_CYC(SC)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6), .cmd_op(cmd_op6), .cmd_addr(cmd_addr6),
    .dac_bus(dac6), .arr_in(arr_in6), .arr_out(arr_out6),
    .adc_bus(adc_bus6), .adc_valid(adc_valid6), .adc_ready(adc_ready6), .adc_group(adc_group6),
    .busy(busy6), .done(done6), .err(err6)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected ADC transfers (group index + N_DAC voltages per entry).
  int  exp_grp_q [$];
  real exp_bus_q [$];
  logic rdy_toggle = 1'b0;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real exp);
    checks++;
    if ((act - exp) > 1.0e-9 || (exp - act) > 1.0e-9) begin
      errors++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  // Monitor: every cycle adc_valid is up, bus must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && adc_valid) begin
      if (exp_grp_q.size() == 0) begin
        chk_int("unexpected_adc_valid", 1, 0);
      end else begin
        chk_int("adc_group", int'(adc_group), exp_grp_q[0]);
        for (int j = 0; j < ND; j++) chk_real($sformatf("adc_bus[%0d]", j), adc_bus[j], exp_bus_q[j]);
        if (adc_ready) begin
          void'(exp_grp_q.pop_front());
          for (int j = 0; j < ND; j++) void'(exp_bus_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_toggle) adc_ready = ~adc_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_grp(input int g);
    exp_grp_q.push_back(g);
    for (int j = 0; j < ND; j++) exp_bus_q.push_back(real'(8*g + j) * 0.01);
  endtask

  // Returns one cycle after the accept edge (first SETTLE cycle), #1 past the edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] addr);
    @(posedge clk); #1;
    cmd_op = op; cmd_addr = addr; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic issue6(input logic [1:0] op, input logic [4:0] addr);
    @(posedge clk); #1;
    cmd_op6 = op; cmd_addr6 = addr; cmd_valid6 = 1'b1;
    @(posedge clk); #1;
    cmd_valid6 = 1'b0;
  endtask

  // busy high cycles 1..SC+1 after accept, done exactly at SC+1.
  task automatic check_load_timing(input string name);
    for (int k = 1; k <= SC + 2; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk_int($sformatf("%s_busy_c%0d", name, k), int'(busy), (k <= SC + 1) ? 1 : 0);
      chk_int($sformatf("%s_done_c%0d", name, k), int'(done), (k == SC + 1) ? 1 : 0);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin @(posedge clk); #1; n++; end
    chk_int({name, "_done_seen"}, int'(done), 1);
  endtask

  initial begin
    int zero_ok;
    for (int j = 0; j < ND; j++) dac_bus[j] = 0.0;
    for (int i = 0; i < NSL; i++) arr_in[i] = 0.0;
    for (int j = 0; j < ND6; j++) dac6[j] = 0.0;
    for (int i = 0; i < NSL6; i++) arr_in6[i] = 0.0;

    // Reset state
    #12;
    chk_int("rst_adc_valid", int'(adc_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_done", int'(done), 0);
    chk_int("rst_err", int'(err), 0);
    chk_int("rst_adc_group", int'(adc_group), 0);
    for (int i = 0; i < NSL; i++) chk_real($sformatf("rst_arr_out[%0d]", i), arr_out[i], 0.0);
    for (int j = 0; j < ND; j++) chk_real($sformatf("rst_adc_bus[%0d]", j), adc_bus[j], 0.0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk_int("rst_cmd_ready", int'(cmd_ready), 1);

    // LOAD_ALL 0.1..0.8
    for (int j = 0; j < ND; j++) dac_bus[j] = real'(j + 1) * 0.1;
    issue(2'd0, 5'd0);
    check_load_timing("load_all");
    for (int i = 0; i < NSL; i++)
      chk_real($sformatf("load_all_line[%0d]", i), arr_out[i], real'((i % 8) + 1) * 0.1);

    // LOAD_ALL 0.5 then LOAD_ADDR 13 with dac_bus[5]=1.2
    for (int j = 0; j < ND; j++) dac_bus[j] = 0.5;
    issue(2'd0, 5'd0);
    wait_done("load_half", 10);
    for (int j = 0; j < ND; j++) dac_bus[j] = 0.9;
    dac_bus[5] = 1.2;
    issue(2'd1, 5'd13);
    check_load_timing("load_addr");
    for (int i = 0; i < NSL; i++)
      chk_real($sformatf("load_addr_line[%0d]", i), arr_out[i], (i == 13) ? 1.2 : 0.5);

    // READ_ALL with toggling ready
    for (int i = 0; i < NSL; i++) arr_in[i] = real'(i) * 0.01;
    for (int g = 0; g < NG; g++) push_grp(g);
    adc_ready = 1'b0;
    rdy_toggle = 1'b1;
    issue(2'd3, 5'd0);
    begin
      int n;
      n = 0;
      while (!done && n < 40) begin
        zero_ok = 1;
        for (int i = 0; i < NSL; i++) if (arr_out[i] != 0.0) zero_ok = 0;
        chk_int("read_all_arr_out_zero", zero_ok, 1);
        @(posedge clk); #1; n++;
      end
    end
    chk_int("read_all_done_seen", int'(done), 1);
    chk_int("read_all_all_xfers_before_done", exp_grp_q.size(), 0);
    zero_ok = 1;
    for (int i = 0; i < NSL; i++) if (arr_out[i] != 0.0) zero_ok = 0;
    chk_int("read_all_arr_out_zero_in_done", zero_ok, 1);
    rdy_toggle = 1'b0;
    adc_ready = 1'b1;
    @(posedge clk); #1;
    chk_int("read_all_idle", int'(busy), 0);
    for (int i = 0; i < NSL; i++)
      chk_real($sformatf("read_all_restore[%0d]", i), arr_out[i], (i == 13) ? 1.2 : 0.5);

    // READ_GRP addr 20 -> group 2, valid at cycle 3, done at cycle 4
    push_grp(2);
    issue(2'd2, 5'd20);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      chk_int($sformatf("read_grp_valid_c%0d", k), int'(adc_valid), (k == 3) ? 1 : 0);
      chk_int($sformatf("read_grp_done_c%0d", k), int'(done), (k == 4) ? 1 : 0);
    end
    chk_int("read_grp_sb_empty", exp_grp_q.size(), 0);

    // 6x3 instance: illegal LOAD_ADDR, then command while busy
    for (int j = 0; j < ND6; j++) dac6[j] = 0.3;
    issue6(2'd0, 5'd0);
    repeat (SC + 1) begin @(posedge clk); #1; end
    chk_int("n6_idle_after_load", int'(busy6), 0);
    for (int j = 0; j < ND6; j++) dac6[j] = 0.9;
    issue6(2'd1, 5'd20);
    chk_int("n6_err_pulse", int'(err6), 1);
    chk_int("n6_err_busy", int'(busy6), 0);
    chk_int("n6_err_done", int'(done6), 0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      chk_int($sformatf("n6_err_low_c%0d", k), int'(err6), 0);
      chk_int($sformatf("n6_no_done_c%0d", k), int'(done6), 0);
    end
    for (int i = 0; i < NSL6; i++) chk_real($sformatf("n6_line_keep[%0d]", i), arr_out6[i], 0.3);

    for (int j = 0; j < ND6; j++) dac6[j] = 0.7;
    issue6(2'd0, 5'd0);
    chk_int("n6_cmd_ready_busy", int'(cmd_ready6), 0);
    for (int j = 0; j < ND6; j++) dac6[j] = 0.1;
    cmd_op6 = 2'd0; cmd_valid6 = 1'b1;
    @(posedge clk); #1;
    cmd_valid6 = 1'b0;
    @(posedge clk); #1;
    chk_int("n6_done_first", int'(done6), 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_int($sformatf("n6_no_second_busy_%0d", k), int'(busy6), 0);
    end
    for (int i = 0; i < NSL6; i++) chk_real($sformatf("n6_line_busy_ignored[%0d]", i), arr_out6[i], 0.7);

    // Reset during XFER of READ_ALL
    adc_ready = 1'b0;
    push_grp(0);
    issue(2'd3, 5'd0);
    begin
      int n;
      n = 0;
      while (!adc_valid && n < 10) begin @(posedge clk); #1; n++; end
    end
    chk_int("rst_mid_reached_xfer", int'(adc_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_int("rst_mid_adc_valid", int'(adc_valid), 0);
    chk_int("rst_mid_busy", int'(busy), 0);
    chk_int("rst_mid_done", int'(done), 0);
    for (int i = 0; i < NSL; i++) chk_real($sformatf("rst_mid_arr_out[%0d]", i), arr_out[i], 0.0);
    exp_grp_q.delete();
    exp_bus_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    adc_ready = 1'b1;
    for (int i = 0; i < NSL; i++) chk_real($sformatf("rst_mid_line_clear[%0d]", i), arr_out[i], 0.0);
    for (int j = 0; j < ND; j++) dac_bus[j] = real'(j + 1) * 0.1;
    issue(2'd0, 5'd0);
    check_load_timing("post_rst_load");
    for (int i = 0; i < NSL; i++)
      chk_real($sformatf("post_rst_line[%0d]", i), arr_out[i], real'((i % 8) + 1) * 0.1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
